// File: rtl/spi_pkg.sv
// Shared definitions for the SPI endpoint: default frame width, master
// state encoding and the high-impedance constant used by the line drivers.
package spi_pkg;

    // Default frame length in bits.
    localparam int DEFAULT_DATA_WIDTH = 8;

    // Master sequencing: one cs-high cycle, then DATA_WIDTH bit cycles.
    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } master_state_e;

    // Value placed on a shared line when this endpoint releases it.
    localparam logic HIZ = 1'bz;

endpackage : spi_pkg

// File: rtl/spi_shift_reg.sv
// DATA_WIDTH-bit shift register with parallel load, serial in and serial out.
// Shift direction is fixed at build time by SPI_LSB_FIRST_EN:
//   undefined : line bit is q[MSB], shifts left, serial-in enters at q[0]
//   defined   : line bit is q[0],   shifts right, serial-in enters at q[MSB]
// 'next' is the value the register takes on a shift, so the owner can
// capture a completed word on the same edge as the final shift.
module spi_shift_reg
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  shift,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  sin,
    output logic [DATA_WIDTH-1:0] next,
    output logic                  sout
);

    logic [DATA_WIDTH-1:0] q;

`ifdef SPI_LSB_FIRST_EN
    assign next = {sin, q[DATA_WIDTH-1:1]};
    assign sout = q[0];
`else
    assign next = {q[DATA_WIDTH-2:0], sin};
    assign sout = q[DATA_WIDTH-1];
`endif

    // Load has priority over shift; otherwise hold.
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples its inputs from before the edge, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= din;
        end else if (shift) begin
            q <= next;
        end
    end

endmodule : spi_shift_reg

// File: rtl/spi_master_slave.sv
// Single-mode-selectable SPI endpoint (p_master strap: 1=master, 0=slave).
// Two instances share cs/mosi/miso and the bit clock sck. The master sends
// back-to-back DATA_WIDTH-bit frames (one cs-high cycle between frames), full
// duplex; the slave answers with its own p_data_in. Both ends shift on the
// same posedge, capturing the bit held on the line before the edge.
// Build option: define SPI_LSB_FIRST_EN for LSB-first frames (both
// instances of a pair must use the same setting).
module spi_master_slave
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  sck,
    input  logic                  reset,
    input  logic                  p_master,
    input  logic [DATA_WIDTH-1:0] p_data_in,
    inout  wire                   cs,
    inout  wire                   mosi,
    inout  wire                   miso,
    output logic [DATA_WIDTH-1:0] p_data_out,
    output logic                  p_done
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    master_state_e         state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  cs_q;
    logic                  cs_sel;
    logic                  sr_load;
    logic                  sr_shift;
    logic                  sr_sin;
    logic                  sr_sout;
    logic [DATA_WIDTH-1:0] sr_next;

    // Slave select decode: only a clean 0 selects; X or Z counts as deselected.
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        cs_sel = 1'b0;
        if (cs == 1'b0) begin
            cs_sel = 1'b1;
        end
    end

    // Shift register control. In slave mode one register serves as both tx
    // and rx: each outgoing bit leaves the line end as an incoming bit enters
    // the other end, so after DATA_WIDTH shifts it holds the received word
    // while miso has shown exactly the loaded word.
    always_comb begin
        sr_load  = 1'b0;
        sr_shift = 1'b0;
        sr_sin   = 1'b0;
        if (p_master) begin
            sr_load  = (state_q == IDLE);
            sr_shift = (state_q == XFER);
            sr_sin   = miso;
        end else begin
            sr_load  = !cs_sel;
            sr_shift = cs_sel;
            sr_sin   = mosi;
        end
    end

    spi_shift_reg #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_shift (
        .clk   (sck),
        .rst_n (reset),
        .load  (sr_load),
        .shift (sr_shift),
        .din   (p_data_in),
        .sin   (sr_sin),
        .next  (sr_next),
        .sout  (sr_sout)
    );

    // Master FSM and slave bit counter with registered cs, p_data_out, p_done.
    always_ff @(posedge sck or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            cs_q       <= 1'b1;
            p_data_out <= '0;
            p_done     <= 1'b0;
        end else begin
            p_done <= 1'b0;
            if (p_master) begin
                case (state_q)
                    IDLE: begin
                        cnt_q   <= '0;
                        cs_q    <= 1'b0;
                        state_q <= XFER;
                    end
                    XFER: begin
                        if (cnt_q == LAST_BIT) begin
                            cnt_q      <= '0;
                            p_data_out <= sr_next;
                            p_done     <= 1'b1;
                            cs_q       <= 1'b1;
                            state_q    <= IDLE;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                endcase
            end else begin
                state_q <= IDLE;
                cs_q    <= 1'b1;
                if (!cs_sel) begin
                    cnt_q <= '0;
                end else if (cnt_q == LAST_BIT) begin
                    cnt_q      <= '0;
                    p_data_out <= sr_next;
                    p_done     <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    // Line drivers: master owns cs and mosi, slave owns miso only while selected.
    assign cs   = p_master ? cs_q : HIZ;
    assign mosi = p_master ? ((state_q == XFER) ? sr_sout : 1'b0) : HIZ;
    assign miso = (!p_master && cs_sel) ? sr_sout : HIZ;

endmodule : spi_master_slave

// File: tb/tb_spi_master_slave.sv
// Self-checking bench for a master/slave pair of spi_master_slave sharing
// cs/mosi/miso. A pullup on miso makes a released line read as 1.
// Expected line bits and received words come from the frame rules: bit i of
// a frame is word[DW-1-i] (word[i] when SPI_LSB_FIRST_EN), and each side
// receives the word the other side held at the frame's load edge.
module tb_spi_master_slave;

    localparam int DW = 8;

    typedef struct {
        logic [DW-1:0] m_word;
        logic [DW-1:0] s_word;
        bit            mid_en;
        logic [DW-1:0] mid_m;
        logic [DW-1:0] exp_s_rx;
        logic [DW-1:0] exp_m_rx;
    } vec_t;

    logic          sck = 1'b0;
    logic          reset;
    logic [DW-1:0] m_din;
    logic [DW-1:0] s_din;
    logic [DW-1:0] m_dout;
    logic [DW-1:0] s_dout;
    logic          m_done;
    logic          s_done;
    wire           cs;
    wire           mosi;
    wire           miso;

    int n_checks = 0;
    int n_pass   = 0;

    vec_t vecs[7];

    pullup pu_miso (miso);

    always #5 sck = ~sck;

    spi_master_slave #(.DATA_WIDTH(DW)) u_mst (
        .sck        (sck),
        .reset      (reset),
        .p_master   (1'b1),
        .p_data_in  (m_din),
        .cs         (cs),
        .mosi       (mosi),
        .miso       (miso),
        .p_data_out (m_dout),
        .p_done     (m_done)
    );

    spi_master_slave #(.DATA_WIDTH(DW)) u_slv (
        .sck        (sck),
        .reset      (reset),
        .p_master   (1'b0),
        .p_data_in  (s_din),
        .cs         (cs),
        .mosi       (mosi),
        .miso       (miso),
        .p_data_out (s_dout),
        .p_done     (s_done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic line_bit(input logic [DW-1:0] w, input int i);
`ifdef SPI_LSB_FIRST_EN
        return w[i];
`else
        return w[DW-1-i];
`endif
    endfunction

    // Called at a negedge whose next posedge is a frame load edge.
    task automatic run_frame(input string tag, input vec_t v);
        m_din = v.m_word;
        s_din = v.s_word;
        for (int i = 0; i < DW; i++) begin
            @(negedge sck);
            if (v.mid_en && i == 3) m_din = v.mid_m;
            check($sformatf("%s cs b%0d", tag, i), {31'b0, cs}, 32'd0);
            check($sformatf("%s mosi b%0d", tag, i), {31'b0, mosi}, {31'b0, line_bit(v.m_word, i)});
            check($sformatf("%s miso b%0d", tag, i), {31'b0, miso}, {31'b0, line_bit(v.s_word, i)});
            check($sformatf("%s dones b%0d", tag, i), {30'b0, m_done, s_done}, 32'd0);
        end
        @(negedge sck);
        check({tag, " cs end"}, {31'b0, cs}, 32'd1);
        check({tag, " miso released"}, {31'b0, miso}, 32'd1);
        check({tag, " dones end"}, {30'b0, m_done, s_done}, 32'd3);
        check({tag, " slave rx"}, {24'b0, s_dout}, {24'b0, v.exp_s_rx});
        check({tag, " master rx"}, {24'b0, m_dout}, {24'b0, v.exp_m_rx});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t v;

        // {m_word, s_word, mid_en, mid_m, exp_s_rx, exp_m_rx}
        vecs[0] = '{8'hE9, 8'h5A, 1'b1, 8'h3C, 8'hE9, 8'h5A};
        vecs[1] = '{8'h3C, 8'hC3, 1'b0, 8'h00, 8'h3C, 8'hC3};
        vecs[2] = '{8'h00, 8'hFF, 1'b0, 8'h00, 8'h00, 8'hFF};
        vecs[3] = '{8'hFF, 8'h00, 1'b0, 8'h00, 8'hFF, 8'h00};
        vecs[4] = '{8'h80, 8'h01, 1'b0, 8'h00, 8'h80, 8'h01};
        vecs[5] = '{8'h01, 8'h80, 1'b0, 8'h00, 8'h01, 8'h80};
        vecs[6] = '{8'hA5, 8'h5A, 1'b1, 8'hFF, 8'hA5, 8'h5A};

        reset = 1'b0;
        m_din = '0;
        s_din = '0;
        repeat (5) @(negedge sck);
        check("rst cs", {31'b0, cs}, 32'd1);
        check("rst mosi", {31'b0, mosi}, 32'd0);
        check("rst miso released", {31'b0, miso}, 32'd1);
        check("rst master dout", {24'b0, m_dout}, 32'd0);
        check("rst slave dout", {24'b0, s_dout}, 32'd0);
        check("rst master done", {31'b0, m_done}, 32'd0);
        check("rst slave done", {31'b0, s_done}, 32'd0);
        reset = 1'b1;

        // Table-driven back-to-back frames.
        for (int k = 0; k < 7; k++) begin
            run_frame($sformatf("vec%0d", k), vecs[k]);
        end

        // Reset after four bits of a frame aborts it.
        m_din = 8'hC6;
        s_din = 8'h39;
        for (int i = 0; i < 4; i++) begin
            @(negedge sck);
            check($sformatf("abort mosi b%0d", i), {31'b0, mosi}, {31'b0, line_bit(8'hC6, i)});
        end
        @(posedge sck);
        #2 reset = 1'b0;
        #1;
        check("abort cs async", {31'b0, cs}, 32'd1);
        check("abort mosi", {31'b0, mosi}, 32'd0);
        check("abort miso released", {31'b0, miso}, 32'd1);
        check("abort master dout", {24'b0, m_dout}, 32'd0);
        check("abort slave dout", {24'b0, s_dout}, 32'd0);
        repeat (3) begin
            @(negedge sck);
            check("abort no done", {30'b0, m_done, s_done}, 32'd0);
        end
        reset = 1'b1;
        v = '{8'hC6, 8'h39, 1'b0, 8'h00, 8'hC6, 8'h39};
        run_frame("post-abort", v);

        // Randomized frames against the frame-level model.
        for (int k = 0; k < 16; k++) begin
            v.m_word   = DW'($urandom);
            v.s_word   = DW'($urandom);
            v.mid_en   = 1'($urandom_range(1, 0));
            v.mid_m    = DW'($urandom);
            v.exp_s_rx = v.m_word;
            v.exp_m_rx = v.s_word;
            run_frame($sformatf("rnd%0d", k), v);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_spi_master_slave

// File: doc/spi_master_slave.md
Name: spi_master_slave

Overview:
- Single-mode-selectable SPI endpoint. Strap p_master=1 for master, p_master=0 for slave.
- Two instances share the cs/mosi/miso nets (bidirectional, tri-stated) and the same clock sck, which is also the bit clock.
- The master sends back-to-back 8-bit frames from p_data_in, full duplex, MSB first; the slave answers with its own p_data_in.

Parameters:
DATA_WIDTH, 8, frame length in bits; bit counter is $clog2(DATA_WIDTH) wide.

Ports:
sck  input  1  system and SPI bit clock; all state on posedge
reset  input  1  asynchronous, active-low reset
p_master  input  1  static mode strap: 1=master, 0=slave
p_data_in  input  DATA_WIDTH  word to transmit; sampled at frame load
cs  inout  1  chip select, active low; driven by master, Z in slave
mosi  inout  1  master-out data; driven by master, Z in slave
miso  inout  1  slave-out data; driven by slave only while cs==0, else Z; master never drives
p_data_out  output  DATA_WIDTH  last complete received word
p_done  output  1  one-cycle pulse when p_data_out updates

Behaviour:
- Reset (reset==0, async):
  - Master: cs=1, mosi=0, FSM=IDLE.
  - Slave: miso=Z, bit count=0.
  - Both modes: p_data_out=0, p_done=0.
  - Reset mid-frame aborts the frame; no p_done for it.
- Master FSM, states IDLE and XFER:
  - IDLE, one cycle with cs=1. Next posedge: shift<=p_data_in, cnt<=0, cs<=0, go XFER.
  - XFER: mosi=shift[MSB] combinationally. Each posedge: shift<={shift[MSB-1:0],miso}, cnt<=cnt+1.
  - On the posedge with cnt==DATA_WIDTH-1: p_data_out<={shift[MSB-1:0],miso}, p_done<=1, cs<=1, go IDLE.
  - Frame period = DATA_WIDTH+1 cycles (1 high + 8 low). Runs continuously while reset is high.
- Slave:
  - When cs!=0 at posedge: tx<=p_data_in, cnt<=0.
  - When cs==0 at posedge: rx<={rx[MSB-1:0],mosi}, tx<={tx[MSB-1:0],1'b0}, cnt<=cnt+1.
  - miso=tx[MSB] while cs==0.
  - On the posedge with cnt==DATA_WIDTH-1: p_data_out<={rx[MSB-1:0],mosi}, p_done<=1, cnt<=0.
- Sampling: both ends sample and shift on the same posedge (registered-vs-registered), so the bit held on the line before the edge is captured.
- p_done is high for exactly one cycle per frame. In a master/slave pair, both instances pulse p_done in the same cycle.
- p_master change while running: undefined; treat as static after reset.
- cs X/Z at the slave is treated as deselected.

Optional Feature:
- Macro SPI_LSB_FIRST_EN.
- Defined: shift direction reversed in both modes.
  - Line bit is shift[0].
  - Shift right; received bit enters at MSB.
  - Frame order is LSB first.
- Undefined: MSB first as above.
- Both instances in a pair must be built with the same setting.

Decomposition:
- Package spi_pkg: DATA_WIDTH default constant, master state enum {IDLE, XFER}, tri-state helper constant for Z.
- One sub-module, spi_shift_reg:
  - Parallel load, serial in, serial out, DATA_WIDTH-bit.
  - Direction fixed by SPI_LSB_FIRST_EN.
  - Used by both master and slave paths.
- Top handles the FSM, bit counter and tri-state drivers.

Test Plan:
- Hold reset=0 for 5 cycles → cs=1, mosi=0, miso=Z, p_data_out=0, p_done=0 on both instances.
- Release reset; master p_data_in=8'hE9, slave p_data_in=8'h5A → first posedge cs falls; mosi sequence 1,1,1,0,1,0,0,1; miso sequence 0,1,0,1,1,0,1,0.
- At end of the 8th low cycle → slave p_data_out=8'hE9, master p_data_out=8'h5A, both p_done high for 1 cycle; cs high for exactly 1 cycle, then the next frame starts.
- Change master p_data_in to 8'h3C during a frame → the current frame still sends E9; the next frame sends 3C.
- Assert reset after 4 bits of a frame → cs=1 immediately (async), miso=Z, no p_done, p_data_out unchanged from its reset value 0; after release a full fresh frame runs.
- With SPI_LSB_FIRST_EN, data E9/5A → mosi 1,0,0,1,0,1,1,1; received words still E9 at slave and 5A at master.
